os_col_drain: RTL and testbench

OS_COL_DRAIN -- requirements
Module: os_col_drain

---
 rtl/os_col_drain_if.sv | 28 ++
 rtl/os_col_drain.sv | 132 +++++++++++++
 tb/tb_os_col_drain.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/os_col_drain_if.sv
// Result stream from the column drain to its consumer.
// Valid/ready handshake carrying one accumulator word per transfer.
interface os_col_drain_if #(
  parameter int ACC_W = 16,
  parameter int IW    = 3
);
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [ACC_W-1:0] OUT_DATA;
  logic [IW-1:0]    OUT_IDX;
  logic             OUT_LAST;

  modport master (
    output OUT_VALID,
    output OUT_DATA,
    output OUT_IDX,
    output OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_DATA,
    input  OUT_IDX,
    input  OUT_LAST,
    output OUT_READY
  );
endinterface

// File: rtl/os_col_drain.sv
// Snapshots a PE column's accumulators and streams them out row by row,
// then strobes a one-cycle accumulator clear back to the column.
module os_col_drain #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ROWS*ACC_W-1:0] MAC_IN,
  os_col_drain_if.master        o,
  output logic                  PE_CLR_N,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN
);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] shadow [ROWS];
  logic             valid_q, valid_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;
  logic             clr_n_q, clr_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             load;
  logic             xfer;
  logic [IW-1:0]    idx_inc;

  assign load    = (state_q == IDLE) && START;
  assign xfer    = valid_q && o.OUT_READY;
  assign idx_inc = idx_q + IW'(1);

  // Shadow bank: captured only on the accepting START edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int r = 0; r < ROWS; r++) shadow[r] <= '0;
    end else if (load) begin
      for (int r = 0; r < ROWS; r++)
        shadow[r] <= MAC_IN[r*ACC_W +: ACC_W];
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    clr_n_d = 1'b1;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (START && (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = MAC_IN[ACC_W-1:0];
          idx_d   = '0;
          last_d  = (ROWS == 1);
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = CLEAR;
            valid_d = 1'b0;
            last_d  = 1'b0;
            clr_n_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            data_d = shadow[idx_inc];
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      clr_n_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      clr_n_q <= clr_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o.OUT_VALID = valid_q;
  assign o.OUT_DATA  = data_q;
  assign o.OUT_IDX   = idx_q;
  assign o.OUT_LAST  = last_q;
  assign PE_CLR_N    = clr_n_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign OVERRUN     = ovr_q;
endmodule

// File: tb/tb_os_col_drain.sv
// Directed bench for the column drain.
// Inputs driven and outputs sampled on the falling edge.
module tb_os_col_drain;
  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [127:0] mac;
  logic         PE_CLR_N;
  logic         BUSY;
  logic         DONE;
  logic         OVERRUN;
  int           checks = 0;
  int           failures = 0;

  os_col_drain_if #(.ACC_W(16), .IW(3)) bus ();

  os_col_drain #(.WIDTH(8), .ROWS(8), .ACC_W(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .MAC_IN(mac),
    .o(bus.master),
    .PE_CLR_N(PE_CLR_N),
    .BUSY(BUSY),
    .DONE(DONE),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic finish_drain();
    int n = 0;
    bus.OUT_READY = 1'b1;
    START = 1'b0;
    while (BUSY && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout busy=%0b want 0", BUSY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    START = 1'b0;
    bus.OUT_READY = 1'b0;
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h0100 + 16'(r);
    repeat (2) tick();
    checks++;
    if ({bus.OUT_VALID, bus.OUT_LAST, PE_CLR_N, BUSY, DONE, OVERRUN}
        !== 6'b001000) begin
      failures++;
      $display("FAIL rst_flags got=%b want=001000",
        {bus.OUT_VALID, bus.OUT_LAST, PE_CLR_N, BUSY, DONE, OVERRUN});
    end
    checks++;
    if (bus.OUT_DATA !== 16'h0 || bus.OUT_IDX !== 3'd0) begin
      failures++;
      $display("FAIL rst_data got=%h/%0d want=0000/0",
        bus.OUT_DATA, bus.OUT_IDX);
    end
    RST = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 3'd0 ||
        bus.OUT_DATA !== 16'h0100 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL rst_first_start got v=%b i=%0d d=%h b=%b want 1/0/0100/1",
        bus.OUT_VALID, bus.OUT_IDX, bus.OUT_DATA, BUSY);
    end
    finish_drain();
  endtask

  task automatic test_basic();
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h0100 + 16'(r);
    bus.OUT_READY = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 3'(i) ||
          bus.OUT_DATA !== 16'h0100 + 16'(i) ||
          bus.OUT_LAST !== (i == 7) || PE_CLR_N !== 1'b1) begin
        failures++;
        $display("FAIL basic_row i=%0d got v=%b idx=%0d d=%h l=%b want 1/%0d/%h/%b",
          i, bus.OUT_VALID, bus.OUT_IDX, bus.OUT_DATA, bus.OUT_LAST,
          i, 16'h0100 + 16'(i), (i == 7));
      end
      tick();
    end
    checks++;
    if (PE_CLR_N !== 1'b0 || DONE !== 1'b1 || bus.OUT_VALID !== 1'b0 ||
        BUSY !== 1'b1) begin
      failures++;
      $display("FAIL basic_clear got clr_n=%b done=%b v=%b busy=%b want 0/1/0/1",
        PE_CLR_N, DONE, bus.OUT_VALID, BUSY);
    end
    tick();
    checks++;
    if (PE_CLR_N !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0 ||
        OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got clr_n=%b done=%b busy=%b ovr=%b want 1/0/0/0",
        PE_CLR_N, DONE, BUSY, OVERRUN);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pd;
    logic [2:0]  pi;
    logic        stalled = 1'b0;
    int          n = 0;
    int          cyc = 0;
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h1230 + 16'(r);
    bus.OUT_READY = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    while (n < 8 && cyc < 100) begin
      bus.OUT_READY = (cyc % 3 == 0);
      if (stalled) begin
        checks++;
        if (bus.OUT_DATA !== pd || bus.OUT_IDX !== pi) begin
          failures++;
          $display("FAIL bp_stable cyc=%0d got %h/%0d want %h/%0d",
            cyc, bus.OUT_DATA, bus.OUT_IDX, pd, pi);
        end
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        checks++;
        if (bus.OUT_IDX !== 3'(n) || bus.OUT_DATA !== 16'h1230 + 16'(n)) begin
          failures++;
          $display("FAIL bp_order n=%0d got %h/%0d want %h/%0d",
            n, bus.OUT_DATA, bus.OUT_IDX, 16'h1230 + 16'(n), n);
        end
        n++;
        stalled = 1'b0;
      end else begin
        stalled = bus.OUT_VALID;
        pd = bus.OUT_DATA;
        pi = bus.OUT_IDX;
      end
      tick();
      cyc++;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d want=8", n);
    end
    checks++;
    if (DONE !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_done got done=%b v=%b want 1/0", DONE, bus.OUT_VALID);
    end
    finish_drain();
  endtask

  task automatic test_snapshot();
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h0200 + 16'(r);
    mac[48 +: 16] = 16'hBEEF;
    bus.OUT_READY = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    mac[48 +: 16] = 16'h0000;
    mac[64 +: 16] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        checks++;
        if (bus.OUT_IDX !== 3'd3 || bus.OUT_DATA !== 16'hBEEF) begin
          failures++;
          $display("FAIL snap_row3 got %h/%0d want beef/3",
            bus.OUT_DATA, bus.OUT_IDX);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.OUT_IDX !== 3'd4 || bus.OUT_DATA !== 16'h0204) begin
          failures++;
          $display("FAIL snap_row4 got %h/%0d want 0204/4",
            bus.OUT_DATA, bus.OUT_IDX);
        end
      end
      tick();
    end
    finish_drain();
  endtask

  task automatic test_overrun();
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h0300 + 16'(r);
    bus.OUT_READY = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 3'(i) ||
          bus.OUT_DATA !== 16'h0300 + 16'(i)) begin
        failures++;
        $display("FAIL ovr_row i=%0d got v=%b %h/%0d want 1 %h/%0d",
          i, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_IDX, 16'h0300 + 16'(i), i);
      end
      START = (i == 2);
      tick();
      START = 1'b0;
    end
    checks++;
    if (DONE !== 1'b1 || OVERRUN !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got done=%b ovr=%b want 1/1", DONE, OVERRUN);
    end
    START = 1'b1;
    tick();
    checks++;
    if (BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear_start got busy=%b v=%b want 0/0",
        BUSY, bus.OUT_VALID);
    end
    tick();
    START = 1'b0;
    checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 3'd0 ||
        bus.OUT_DATA !== 16'h0300) begin
      failures++;
      $display("FAIL ovr_restart got v=%b %h/%0d want 1 0300/0",
        bus.OUT_VALID, bus.OUT_DATA, bus.OUT_IDX);
    end
    finish_drain();
    checks++;
    if (OVERRUN !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky got=%b want 1", OVERRUN);
    end
  endtask

  task automatic test_midreset();
    logic bad = 1'b0;
    RST = 1'b0;
    tick();
    checks++;
    if (OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL mr_ovr_clear got=%b want 0", OVERRUN);
    end
    RST = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) mac[r*16 +: 16] = 16'h0400 + 16'(r);
    bus.OUT_READY = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.OUT_IDX !== 3'd4 || bus.OUT_DATA !== 16'h0404) begin
      failures++;
      $display("FAIL mr_pos got %h/%0d want 0404/4", bus.OUT_DATA, bus.OUT_IDX);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.OUT_LAST, PE_CLR_N, BUSY, DONE, OVERRUN}
          !== 6'b001000 ||
        bus.OUT_DATA !== 16'h0 || bus.OUT_IDX !== 3'd0) begin
      failures++;
      $display("FAIL mr_async got flags=%b d=%h i=%0d want 001000/0000/0",
        {bus.OUT_VALID, bus.OUT_LAST, PE_CLR_N, BUSY, DONE, OVERRUN},
        bus.OUT_DATA, bus.OUT_IDX);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (PE_CLR_N !== 1'b1 || DONE !== 1'b0) bad = 1'b1;
    end
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (PE_CLR_N !== 1'b1 || DONE !== 1'b0 ||
          BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL mr_abandon got bad=%b want 0", bad);
    end
  endtask

  task automatic test_boundary();
    for (int r = 0; r < 8; r++)
      mac[r*16 +: 16] = (r % 2 == 0) ? 16'hFFFF : 16'h8000;
    bus.OUT_READY = 1'b1;
    START = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL bnd_ready_early got v=%b busy=%b done=%b want 0/0/0",
        bus.OUT_VALID, BUSY, DONE);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.OUT_IDX !== 3'(i) ||
          bus.OUT_DATA !== ((i % 2 == 0) ? 16'hFFFF : 16'h8000)) begin
        failures++;
        $display("FAIL bnd_data i=%0d got %h/%0d want %h/%0d", i,
          bus.OUT_DATA, bus.OUT_IDX,
          (i % 2 == 0) ? 16'hFFFF : 16'h8000, i);
      end
      tick();
    end
    finish_drain();
  endtask

  initial begin
    mac = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_overrun();
    test_midreset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
